// File: rtl/fp_add_issue_ctrl_if.sv
// rtl/fp_add_issue_ctrl_if.sv - operand, adder and result signals of the FP add issue controller
interface fp_add_issue_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_done;
  logic [31:0] add_out;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_out;
  logic        busy;
  logic        err_timeout;

  modport master (
    output in_valid, in_a, in_b, add_done, add_out, res_ready,
    input  in_ready, add_a, add_b, res_valid, res_out, busy, err_timeout
  );

  modport slave (
    input  in_valid, in_a, in_b, add_done, add_out, res_ready,
    output in_ready, add_a, add_b, res_valid, res_out, busy, err_timeout
  );
endinterface

// File: rtl/fp_add_issue_ctrl.sv
// rtl/fp_add_issue_ctrl.sv - feeds a free-running FP adder from an operand FIFO into a 2-entry result queue
module fp_add_issue_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 32
) (
  input  logic              clk,
  input  logic              rst,
  fp_add_issue_ctrl_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {SYNC, RUN} state_t;

  state_t         state, state_nx;

  logic [31:0]    fifo_a [FIFO_DEPTH];
  logic [31:0]    fifo_b [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    fifo_cnt;

  logic [31:0]    res_q [2];
  logic           res_head;
  logic [1:0]     res_cnt;

  logic [TW-1:0]  tmo_cnt;
  logic [31:0]    add_a_q, add_b_q;
  logic           err_q;

  logic           fifo_full, fifo_nonempty;
  logic           push, issue, capture, res_pop, timeout_hit;
  logic [2:0]     res_after;

  assign fifo_full     = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
  assign fifo_nonempty = (fifo_cnt != '0);
  assign push          = bus.in_valid && !fifo_full;
  assign res_pop       = (res_cnt != 2'd0) && bus.res_ready;
  // Occupancy the result queue will have once this cycle's capture and pop land.
  assign res_after     = {1'b0, res_cnt} + 3'd1 - {2'b00, res_pop};

  // Issue/capture decisions; a new pair may only go out on an add_done cycle.
  always_comb begin
    state_nx    = state;
    issue       = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      SYNC: begin
        if (bus.add_done && fifo_nonempty && (res_cnt < 2'd2)) begin
          issue    = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (bus.add_done) begin
          capture = 1'b1;
          if (fifo_nonempty && (res_after <= 3'd1)) begin
            issue = 1'b1;
          end else begin
            state_nx = SYNC;
          end
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_nx    = SYNC;
        end
      end
      default: state_nx = SYNC;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= SYNC;
    else     state <= state_nx;
  end

  // Operand FIFO storage; contents are only meaningful below fifo_cnt, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr] <= bus.in_a;
      fifo_b[wr_ptr] <= bus.in_b;
    end
  end

  // Operand FIFO pointers and occupancy; push and issue-pop may coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + AW'(1);
      if (issue) rd_ptr <= rd_ptr + AW'(1);
      fifo_cnt <= fifo_cnt + (AW+1)'(push) - (AW+1)'(issue);
    end
  end

  // Adder operand registers, held between issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      add_a_q <= '0;
      add_b_q <= '0;
    end else if (issue) begin
      add_a_q <= fifo_a[rd_ptr];
      add_b_q <= fifo_b[rd_ptr];
    end
  end

  // Two-entry result queue; capture only happens with at most one entry held.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q[0] <= '0;
      res_q[1] <= '0;
      res_head <= 1'b0;
      res_cnt  <= 2'd0;
    end else begin
      if (capture) res_q[res_head ^ res_cnt[0]] <= bus.add_out;
      if (res_pop) res_head <= ~res_head;
      res_cnt <= res_cnt + 2'(capture) - 2'(res_pop);
    end
  end

  // Timeout counter: counts RUN cycles waiting for the outstanding operation.
  always_ff @(posedge clk) begin
    if (rst)                                               tmo_cnt <= '0;
    else if (issue)                                        tmo_cnt <= '0;
    else if (state == RUN && !bus.add_done && !timeout_hit) tmo_cnt <= tmo_cnt + TW'(1);
    else                                                   tmo_cnt <= '0;
  end

  // Sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst)              err_q <= 1'b0;
    else if (timeout_hit) err_q <= 1'b1;
  end

  assign bus.in_ready    = !fifo_full;
  assign bus.add_a       = add_a_q;
  assign bus.add_b       = add_b_q;
  assign bus.res_valid   = (res_cnt != 2'd0);
  assign bus.res_out     = (res_cnt != 2'd0) ? res_q[res_head] : 32'h0;
  assign bus.busy        = (state == RUN) || fifo_nonempty;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_fp_add_issue_ctrl.sv
// tb/tb_fp_add_issue_ctrl.sv - scoreboard bench for fp_add_issue_ctrl with a free-running mock adder
module tb_fp_add_issue_ctrl;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 32;
  localparam int ADD_PERIOD = 3;

  logic clk = 1'b0;
  logic rst;
  logic adder_en;

  always #5 clk = ~clk;

  fp_add_issue_ctrl_if bus();

  fp_add_issue_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q [$];

  int          ad_phase;
  logic [31:0] ad_a, ad_b;
  logic [31:0] prev_a, prev_b;
  logic        prev_done, prev_rst, have_prev;

  // Hand-computed single-precision sums for every pair the bench uses.
  function automatic logic [31:0] fake_sum(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h3F800000_40000000: return 32'h40400000;
      64'h3F800000_3F800000: return 32'h40000000;
      64'h40000000_40000000: return 32'h40800000;
      64'h40400000_C0400000: return 32'h00000000;
      64'h40A00000_00000000: return 32'h40A00000;
      64'h41000000_3F800000: return 32'h41100000;
      64'h41200000_3F800000: return 32'h41300000;
      64'h41800000_3F800000: return 32'h41880000;
      default:               return 32'hDEADBEEF;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r, input bit expect_res);
    int i;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    i = 0;
    while (!bus.in_ready && i < 50) begin
      @(negedge clk);
      i++;
    end
    if (!bus.in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL push_wait: in_ready stayed 0 for pair 0x%08h/0x%08h", a, b);
    end else if (expect_res) begin
      exp_q.push_back(r);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d results still outstanding after %0d cycles", exp_q.size(), budget);
    end
  endtask

  task automatic wait_issue(input logic [31:0] a);
    for (int i = 0; i < 30 && bus.add_a !== a; i++) begin
      @(posedge clk);
      #1;
    end
    chk("issue_seen", bus.add_a, a);
  endtask

  // Mock adder: samples operands the cycle after each done, pulses done every ADD_PERIOD cycles.
  initial begin
    ad_phase     = 0;
    ad_a         = '0;
    ad_b         = '0;
    bus.add_done = 1'b0;
    bus.add_out  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (ad_phase == 0) begin
        ad_a = bus.add_a;
        ad_b = bus.add_b;
      end
      bus.add_done = (ad_phase == ADD_PERIOD - 1) && adder_en;
      bus.add_out  = bus.add_done ? fake_sum(ad_a, ad_b) : 32'h0;
      ad_phase     = (ad_phase + 1) % ADD_PERIOD;
    end
  end

  // Monitor: scoreboard pops on every accepted result; operands may only move after a done or reset.
  initial begin
    have_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (have_prev && (bus.add_a !== prev_a || bus.add_b !== prev_b))
        chk("operand_change_off_done", {31'b0, prev_done | prev_rst}, 32'd1);
      prev_a    = bus.add_a;
      prev_b    = bus.add_b;
      prev_done = bus.add_done;
      prev_rst  = rst;
      have_prev = 1'b1;
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: got 0x%08h with nothing expected", bus.res_out);
        end else begin
          chk("result", bus.res_out, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    adder_en      = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.res_ready = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready",  {31'b0, bus.in_ready},    32'd1);
    chk("rst_res_valid", {31'b0, bus.res_valid},   32'd0);
    chk("rst_res_out",   bus.res_out,              32'h0);
    chk("rst_busy",      {31'b0, bus.busy},        32'd0);
    chk("rst_err",       {31'b0, bus.err_timeout}, 32'd0);
    chk("rst_add_a",     bus.add_a,                32'h0);
    chk("rst_add_b",     bus.add_b,                32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single pair 1.0 + 2.0
    bus.res_ready = 1'b1;
    push(32'h3F800000, 32'h40000000, 32'h40400000, 1'b1);
    drain(60);

    // Fill the FIFO with the adder stalled, then offer a fifth pair on the issue cycle
    adder_en = 1'b0;
    push(32'h3F800000, 32'h3F800000, 32'h40000000, 1'b1);
    push(32'h40000000, 32'h40000000, 32'h40800000, 1'b1);
    push(32'h40400000, 32'hC0400000, 32'h00000000, 1'b1);
    push(32'h40A00000, 32'h00000000, 32'h40A00000, 1'b1);
    chk("full_in_ready", {31'b0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b1;
    bus.in_a     = 32'h41800000;
    bus.in_b     = 32'h3F800000;
    adder_en     = 1'b1;
    for (int i = 0; i < 10 && !bus.add_done; i++) @(negedge clk);
    chk("done_while_full",         {31'b0, bus.add_done}, 32'd1);
    chk("in_ready_on_issue_cycle", {31'b0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("in_ready_after_issue_pop", {31'b0, bus.in_ready}, 32'd1);
    drain(100);

    // Consumer stalled: exactly two results held, third pair not issued
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    push(32'h3F800000, 32'h3F800000, 32'h40000000, 1'b1);
    push(32'h40000000, 32'h40000000, 32'h40800000, 1'b1);
    push(32'h40400000, 32'hC0400000, 32'h00000000, 1'b1);
    push(32'h40A00000, 32'h00000000, 32'h40A00000, 1'b1);
    repeat (40) @(negedge clk);
    chk("stall_res_valid", {31'b0, bus.res_valid}, 32'd1);
    chk("stall_res_head",  bus.res_out,            32'h40000000);
    chk("stall_add_a",     bus.add_a,              32'h40000000);
    chk("stall_busy",      {31'b0, bus.busy},      32'd1);
    @(posedge clk);
    #1;
    bus.res_ready = 1'b1;
    drain(100);

    // Timeout: adder goes silent right after the issue
    push(32'h41000000, 32'h3F800000, 32'h0, 1'b0);
    wait_issue(32'h41000000);
    adder_en = 1'b0;
    repeat (TIMEOUT) @(negedge clk);
    chk("err_before_timeout", {31'b0, bus.err_timeout}, 32'd0);
    @(negedge clk);
    chk("err_at_timeout",     {31'b0, bus.err_timeout}, 32'd1);
    chk("timeout_busy",       {31'b0, bus.busy},        32'd0);
    chk("timeout_res_valid",  {31'b0, bus.res_valid},   32'd0);
    @(posedge clk);
    #1;
    adder_en = 1'b1;
    repeat (12) @(negedge clk);
    chk("timeout_no_late_result", {31'b0, bus.res_valid},   32'd0);
    chk("err_sticky",             {31'b0, bus.err_timeout}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("err_cleared_by_rst", {31'b0, bus.err_timeout}, 32'd0);

    // Reset while an operation is outstanding
    push(32'h41200000, 32'h3F800000, 32'h0, 1'b0);
    wait_issue(32'h41200000);
    chk("run_busy", {31'b0, bus.busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_add_a",     bus.add_a,              32'h0);
    chk("mid_rst_add_b",     bus.add_b,              32'h0);
    chk("mid_rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
    chk("mid_rst_res_valid", {31'b0, bus.res_valid}, 32'd0);
    repeat (10) @(negedge clk);
    chk("mid_rst_no_capture", {31'b0, bus.res_valid}, 32'd0);
    chk("mid_rst_idle",       {31'b0, bus.busy},      32'd0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fp_add_issue_ctrl.md
FP_ADD_ISSUE_CTRL -- requirements
Module: fp_add_issue_ctrl

Interface
REQ-001: Parameter FIFO_DEPTH, default 4, operand-pair FIFO depth (power of two, >=2).
REQ-002: Parameter TIMEOUT, default 32, maximum cycles allowed between issue and adder done.
REQ-003: clk  input  1  single clock; all state updates on its rising edge.
REQ-004: rst  input  1  reset, synchronous and active-high.
REQ-005: in_valid  input  1  operand pair offered.
REQ-006: in_ready  output  1  operand FIFO not full.
REQ-007: in_a, in_b  input  32 each  IEEE 754 single-precision operands.
REQ-008: add_a, add_b  output  32 each  operands driven to the adder, held constant between issues.
REQ-009: add_done  input  1  adder one-cycle done pulse.
REQ-010: add_out  input  32  adder sum, valid while add_done=1.
REQ-011: res_valid  output  1  result queue non-empty.
REQ-012: res_ready  input  1  consumer accepts result.
REQ-013: res_out  output  32  result queue head.
REQ-014: busy  output  1  high when state is RUN or FIFO non-empty.
REQ-015: err_timeout  output  1  sticky timeout flag.

Function
REQ-016: Input push occurs when in_valid && in_ready; FIFO is first-in-first-out, FIFO_DEPTH entries of {in_a,in_b}.
REQ-017: Result queue holds 2 entries; pop occurs when res_valid && res_ready; res_out shows head combinationally from registers.
REQ-018: Adder free-runs; an issue SHALL occur only on a cycle where add_done=1, loading add_a/add_b from FIFO head at that edge, so the adder's next sampling cycle sees the new pair.
REQ-019: States: SYNC (no operation outstanding) and RUN (one operation outstanding).
REQ-020: SYNC: on add_done=1 with FIFO non-empty and result count < 2 -> issue, go RUN; add_done ignored otherwise; add_out never captured in SYNC.
REQ-021: RUN: on add_done=1 -> push add_out into result queue; same edge, issue next pair iff FIFO non-empty and (count + 1 - pop) <= 1, stay RUN; else go SYNC.
REQ-022: Result queue SHALL never overflow; simultaneous capture and pop in the same cycle both take effect.
REQ-023: Simultaneous FIFO push and issue-pop in the same cycle both take effect; push to full FIFO is blocked by in_ready=0 even if a pop occurs that cycle.
REQ-024: Timeout counter clears on each issue, increments each RUN cycle without add_done; on reaching TIMEOUT -> set err_timeout, discard the outstanding operation (no result), go SYNC.
REQ-025: err_timeout clears only on rst.
REQ-026: Results delivered in issue order; each issued pair produces exactly one result unless timed out.
REQ-027: Latency: result appears at the edge of the second add_done after the pair reaches FIFO head with resources free (one done to issue, one to complete).
REQ-028: Back-to-back throughput: one result per adder operation while res_ready=1 and FIFO non-empty.

Reset
REQ-029: On rst=1 at a clock edge: state=SYNC, FIFO and result queue emptied, add_a=add_b=0, err_timeout=0, timeout counter=0.
REQ-030: Outputs during/after reset: in_ready=1, res_valid=0, res_out=0, busy=0.
REQ-031: rst mid-operation discards the outstanding operation; a later add_done SHALL NOT be captured.

Verification
REQ-032: Push 0x3F800000/0x40000000 (1.0+2.0), res_ready=1 -> add_a/add_b change only at an add_done edge; single result 0x40400000.
REQ-033: Push 4 pairs back-to-back (FIFO_DEPTH=4) -> in_ready=0 after 4th push; results 1+1=0x40000000, 2+2=0x40800000, 3+(-3)=0x00000000, 0x40A00000+0 = 0x40A00000 in order.
REQ-034: res_ready=0 with 4 pairs queued -> exactly 2 results held, no issue while count=2; raising res_ready resumes, no loss/duplicate.
REQ-035: Hold add_done=0 for TIMEOUT cycles after issue -> err_timeout=1, state SYNC, no result; sticky until rst.
REQ-036: Assert rst in RUN, then add_done pulse -> res_valid stays 0, add_a=add_b=0, in_ready=1.
REQ-037: Push in the same cycle an issue pops a full FIFO -> push refused (in_ready=0), FIFO count decreases by 1.
